ipv4_hdr_collector: RTL and testbench
=====================================

// Module: ipv4_hdr_collector
// PURPOSE
//  Upstream feeder for the IPv4 header checksum stage. Accepts a byte stream (valid/ready, sop/eop)
//  and assembles the first IHL*4 bytes, big-endian, into six 32-bit header words ih1..ih6.
//  Presents ih1..ih6 with a hdr_valid/hdr_ack handshake, then discards the payload up to eop.
//  ih1..ih6 connect directly to the checksum stage's ih1..ih6 inputs.
// PARAMETERS
//  EXPECT_VER  4  required value of the version nibble (byte 0 [7:4])
//  ZERO_CSUM   1  1: bytes 10-11 (checksum field) are loaded as 0x00 into ih3[15:0]; 0: loaded as received
// PORTS
//  clk        in   1   single clock; all logic on the rising edge
//  rst_n      in   1   asynchronous, active-low reset
//  in_valid   in   1   in_data/in_sop/in_eop are valid
//  in_ready   out  1   collector accepts a byte; transfer occurs when in_valid & in_ready
//  in_data    in   8   stream byte; byte 0 is the first byte of the header
//  in_sop     in   1   first byte of a packet
//  in_eop     in   1   last byte of a packet
//  ih1..ih6   out  32  header words; ihN[31:24] = byte 4*(N-1)
//  hdr_valid  out  1   ih1..ih6 hold a complete header; held until hdr_ack
//  hdr_ack    in   1   consumer has taken the header; sampled only while hdr_valid=1
//  hdr_err    out  1   one-cycle pulse: packet rejected or abandoned
// BEHAVIOUR
//  Reset (asynchronous): state=IDLE, byte_cnt=0, ih1..ih6=0, hdr_valid=0, hdr_err=0, in_ready=1.
//  in_ready = 1 in IDLE, COLLECT and DRAIN; 0 in HOLD.
//  States:
//  - IDLE: bytes without sop are dropped. On a sop byte:
//    - if byte[7:4]==EXPECT_VER and byte[3:0] is 5 or 6: store it, clear ih2..ih6, byte_cnt=1, go to COLLECT.
//    - otherwise: pulse hdr_err; go to DRAIN, or stay in IDLE if eop is on the same byte.
//  - COLLECT: each accepted byte is written at offset byte_cnt, then byte_cnt increments.
//    - Header length is IHL*4 bytes: 20 or 24.
//    - When IHL=5, ih6 stays 0. A zero word leaves the checksum sum unchanged.
//  - COLLECT -> HOLD: on acceptance of the final header byte. hdr_valid rises the next cycle (latency 1).
//    Record whether that byte carried eop.
//  - COLLECT, eop before the final header byte: pulse hdr_err, return to IDLE, hdr_valid stays 0.
//  - COLLECT, sop mid-header: pulse hdr_err for the abandoned packet.
//    Process the byte as a fresh sop (IDLE rules) in the same cycle.
//  - HOLD: hdr_valid=1, ih1..ih6 stable, input stalled. On hdr_ack, hdr_valid falls the next cycle.
//    Go to IDLE if eop was already seen, otherwise to DRAIN.
//  - DRAIN: accept and discard bytes until an eop byte is accepted, then IDLE.
//    A sop in DRAIN is treated as a new packet (IDLE rules); no error is raised.
//  Boundaries:
//  - byte_cnt is 5 bits, range 0..23, and never wraps.
//  - A byte with sop & eop both set is a 1-byte packet: hdr_err, back to IDLE.
//  - hdr_ack while hdr_valid=0 is ignored.
//  - rst_n asserted mid-packet: immediate return to reset values. The remainder of that packet
//    arrives without sop and is dropped in IDLE.
//  - ih1..ih6 may change only in COLLECT; they hold their last value in HOLD, DRAIN and IDLE.
// STRUCTURE
//  Shared package ipv4_pkg:
//  - state encoding IDLE/COLLECT/HOLD/DRAIN
//  - IPV4_VER=4, IHL_MIN=5, IHL_MAX=6
//  - CSUM_OFS_HI=10, CSUM_OFS_LO=11
//  Single flat module: one FSM, byte counter, 24-byte header register, byte-write decode.
//  No sub-module; the checksum stage is instantiated at the next level up.
// TESTING
//  1. 20B header 45 00 00 1c 00 01 00 00 40 11 ab cd c0 a8 00 01 c0 a8 00 c7, eop on byte 19
//     -> ih1=4500001c ih2=00010000 ih3=40110000 (ZERO_CSUM=1) ih4=c0a80001 ih5=c0a800c7 ih6=0;
//     hdr_valid 1 cycle after byte 19; then IDLE.
//  2. IHL=6, 24 bytes plus 8 payload bytes
//     -> ih6 = bytes 20..23, hdr_valid; after ack, 8 bytes drained, IDLE at eop.
//  3. Valid header, hdr_ack held low 5 cycles -> in_ready=0 and ih1..ih6 stable throughout;
//     ack -> hdr_valid=0 next cycle.
//  4. First byte 0x65 (version 6) -> hdr_err pulse, bytes drained to eop, hdr_valid never rises.
//  5. eop on byte 11 of an IHL=5 header -> hdr_err pulse, IDLE; a following good packet is collected correctly.
//  6. rst_n low at byte 8, released, a new packet sent
//     -> all outputs 0 during reset, stale bytes dropped, new header correct.

Source files
------------

// File: rtl/ipv4_pkg.sv
// Shared definitions for the IPv4 header front end.
// Includes the FSM encoding, header field offsets and the first-byte qualifier.
package ipv4_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2,
    DRAIN   = 2'd3
  } state_t;

  localparam logic [3:0] IPV4_VER     = 4'd4;
  localparam logic [3:0] IHL_MIN      = 4'd5;
  localparam logic [3:0] IHL_MAX      = 4'd6;
  localparam logic [4:0] CSUM_OFS_HI  = 5'd10;
  localparam logic [4:0] CSUM_OFS_LO  = 5'd11;
  localparam int         HDR_BYTES    = 24;
  localparam logic [4:0] LAST_OFS_MIN = 5'd19;  // final byte offset, IHL=5
  localparam logic [4:0] LAST_OFS_MAX = 5'd23;  // final byte offset, IHL=6

  // A sop byte opens a header only with the expected version and a supported IHL.
  function automatic logic first_byte_ok(input logic [7:0] b, input logic [3:0] ver);
    return (b[7:4] == ver) && ((b[3:0] == IHL_MIN) || (b[3:0] == IHL_MAX));
  endfunction

endpackage

// File: rtl/ipv4_hdr_collector.sv
// Collects the first IHL*4 bytes of an IPv4 packet into six big-endian words,
// hands them over with a valid/ack handshake, then discards the payload to eop.
module ipv4_hdr_collector
  import ipv4_pkg::*;
#(
  parameter logic [3:0] EXPECT_VER = IPV4_VER,
  parameter bit         ZERO_CSUM  = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  input  logic        in_sop,
  input  logic        in_eop,
  output logic [31:0] ih1,
  output logic [31:0] ih2,
  output logic [31:0] ih3,
  output logic [31:0] ih4,
  output logic [31:0] ih5,
  output logic [31:0] ih6,
  output logic        hdr_valid,
  input  logic        hdr_ack,
  output logic        hdr_err
);

  state_t     state_q, state_d;
  logic [4:0] byte_cnt_q, byte_cnt_d;
  logic       ihl6_q, ihl6_d;
  logic       eop_seen_q, eop_seen_d;
  logic       err_q, err_d;
  logic [7:0] hdr_q [HDR_BYTES];

  logic       accept;
  logic       take_sop;
  logic       start_hdr;
  logic       wr_en;
  logic [7:0] wr_byte;
  logic [4:0] last_ofs;
  logic       csum_byte;

  assign in_ready  = (state_q != HOLD);
  assign accept    = in_valid & in_ready;
  assign last_ofs  = ihl6_q ? LAST_OFS_MAX : LAST_OFS_MIN;
  assign csum_byte = (byte_cnt_q == CSUM_OFS_HI) || (byte_cnt_q == CSUM_OFS_LO);
  assign wr_byte   = (ZERO_CSUM && csum_byte) ? 8'h00 : in_data;

  // NOTE: every signal driven here gets a default first, so no path infers a latch.
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    ihl6_d     = ihl6_q;
    eop_seen_d = eop_seen_q;
    err_d      = 1'b0;
    take_sop   = 1'b0;
    start_hdr  = 1'b0;
    wr_en      = 1'b0;

    if (accept) begin
      case (state_q)
        IDLE: take_sop = in_sop;
        COLLECT: begin
          if (in_sop) begin
            // Abandon the partial header; the sop byte restarts collection.
            err_d    = 1'b1;
            take_sop = 1'b1;
          end else begin
            wr_en = 1'b1;
            if (byte_cnt_q == last_ofs) begin
              state_d    = HOLD;
              byte_cnt_d = 5'd0;
              eop_seen_d = in_eop;
            end else if (in_eop) begin
              state_d    = IDLE;
              byte_cnt_d = 5'd0;
              err_d      = 1'b1;
            end else begin
              byte_cnt_d = byte_cnt_q + 5'd1;
            end
          end
        end
        DRAIN: begin
          if (in_sop) take_sop = 1'b1;
          else if (in_eop) state_d = IDLE;
        end
        default: ;
      endcase

      if (take_sop) begin
        if (first_byte_ok(in_data, EXPECT_VER) && !in_eop) begin
          start_hdr  = 1'b1;
          ihl6_d     = (in_data[3:0] == IHL_MAX);
          byte_cnt_d = 5'd1;
          state_d    = COLLECT;
        end else begin
          err_d      = 1'b1;
          byte_cnt_d = 5'd0;
          state_d    = in_eop ? IDLE : DRAIN;
        end
      end
    end

    if ((state_q == HOLD) && hdr_ack) begin
      state_d = eop_seen_q ? IDLE : DRAIN;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      byte_cnt_q <= 5'd0;
      ihl6_q     <= 1'b0;
      eop_seen_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      ihl6_q     <= ihl6_d;
      eop_seen_q <= eop_seen_d;
      err_q      <= err_d;
    end
  end

  // NOTE: the header store is reset because ih1..ih6 must read zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < HDR_BYTES; i++) hdr_q[i] <= 8'h00;
    end else if (start_hdr) begin
      hdr_q[0] <= in_data;
      for (int i = 1; i < HDR_BYTES; i++) hdr_q[i] <= 8'h00;
    end else if (wr_en) begin
      hdr_q[byte_cnt_q] <= wr_byte;
    end
  end

  // An IHL=5 header leaves bytes 20..23 cleared, so ih6 presents a neutral zero word.
  assign ih1 = {hdr_q[0],  hdr_q[1],  hdr_q[2],  hdr_q[3]};
  assign ih2 = {hdr_q[4],  hdr_q[5],  hdr_q[6],  hdr_q[7]};
  assign ih3 = {hdr_q[8],  hdr_q[9],  hdr_q[10], hdr_q[11]};
  assign ih4 = {hdr_q[12], hdr_q[13], hdr_q[14], hdr_q[15]};
  assign ih5 = {hdr_q[16], hdr_q[17], hdr_q[18], hdr_q[19]};
  assign ih6 = {hdr_q[20], hdr_q[21], hdr_q[22], hdr_q[23]};

  assign hdr_valid = (state_q == HOLD);
  assign hdr_err   = err_q;

endmodule

// File: tb/tb_ipv4_hdr_collector.sv
// Self-checking bench for ipv4_hdr_collector: directed scenarios plus random packets
// checked against a packet-level model of which headers and errors must appear.
module tb_ipv4_hdr_collector;

  typedef logic [5:0][31:0] hdr_t;  // [k] = ih(k+1)

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        in_sop;
  logic        in_eop;
  logic [31:0] ih1, ih2, ih3, ih4, ih5, ih6;
  logic        hdr_valid;
  logic        hdr_ack;
  logic        hdr_err;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   err_seen = 0;
  int   err_exp  = 0;
  int   hdr_seen = 0;
  int   hdr_exp  = 0;
  int   ack_force = -1;
  hdr_t exp_q[$];

  ipv4_hdr_collector dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sop    (in_sop),
    .in_eop    (in_eop),
    .ih1       (ih1),
    .ih2       (ih2),
    .ih3       (ih3),
    .ih4       (ih4),
    .ih5       (ih5),
    .ih6       (ih6),
    .hdr_valid (hdr_valid),
    .hdr_ack   (hdr_ack),
    .hdr_err   (hdr_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Packet-level model: a header is delivered iff the first byte is a v4 IHL 5/6
  // byte and the packet carries at least IHL*4 bytes; otherwise one error pulse.
  function automatic bit model_hdr(input logic [7:0] pkt[$], output hdr_t h);
    int hlen;
    h = '0;
    if (pkt[0][7:4] != 4'd4) return 1'b0;
    if (pkt[0][3:0] == 4'd5) hlen = 20;
    else if (pkt[0][3:0] == 4'd6) hlen = 24;
    else return 1'b0;
    if (pkt.size() < hlen) return 1'b0;
    for (int k = 0; k < hlen; k++)
      if (k != 10 && k != 11) h[k / 4][8 * (3 - k % 4) +: 8] = pkt[k];
    return 1'b1;
  endfunction

  task automatic expect_pkt(input logic [7:0] pkt[$]);
    hdr_t h;
    if (model_hdr(pkt, h)) begin
      exp_q.push_back(h);
      hdr_exp++;
    end else begin
      err_exp++;
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the transfer.
  task automatic send_byte(input logic [7:0] d, input bit s, input bit e);
    int waited = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_sop   = s;
    in_eop   = e;
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) check("ready_timeout", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
  endtask

  task automatic send_pkt(input logic [7:0] pkt[$], input bit with_eop, input bit gaps);
    expect_pkt(pkt);
    for (int i = 0; i < pkt.size(); i++) begin
      if (gaps && $urandom_range(0, 3) == 0) @(negedge clk);
      send_byte(pkt[i], i == 0, with_eop && (i == pkt.size() - 1));
    end
  endtask

  task automatic check_counts(input string tag);
    repeat (4) @(negedge clk);
    check({tag, "_err"}, err_seen, err_exp);
    check({tag, "_hdr"}, hdr_seen, hdr_exp);
  endtask

  // Monitor and consumer: checks each delivered header, its stability and ack timing.
  initial begin
    bit   holding = 1'b0;
    bit   acked   = 1'b0;
    int   wait_left = 0;
    hdr_t cap, cur, exp;
    hdr_ack = 1'b0;
    forever begin
      @(negedge clk);
      cur = {ih6, ih5, ih4, ih3, ih2, ih1};
      if (!rst_n) begin
        holding = 1'b0;
        acked   = 1'b0;
        hdr_ack = 1'b0;
      end else begin
        if (hdr_err) err_seen++;
        if (acked) begin
          check("valid_fall", hdr_valid, 0);
          acked   = 1'b0;
          hdr_ack = 1'b0;
        end else if (hdr_valid) begin
          if (!holding) begin
            holding = 1'b1;
            hdr_seen++;
            cap = cur;
            check("hdr_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
              exp = exp_q.pop_front();
              for (int k = 0; k < 6; k++) check($sformatf("ih%0d", k + 1), cur[k], exp[k]);
            end
            wait_left = (ack_force >= 0) ? ack_force : $urandom_range(0, 6);
          end else begin
            for (int k = 0; k < 6; k++) check($sformatf("hold_ih%0d", k + 1), cur[k], cap[k]);
            check("hold_ready", in_ready, 0);
          end
          if (wait_left == 0) begin
            hdr_ack = 1'b1;
            acked   = 1'b1;
            holding = 1'b0;
          end else begin
            hdr_ack = 1'b0;
            wait_left--;
          end
        end else begin
          hdr_ack = ($urandom_range(0, 3) == 0);  // ignored while no header is held
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] pkt[$];
    logic [7:0] t1[$];
    bit         force_good;

    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_sop = 1'b0; in_eop = 1'b0;
    t1 = '{8'h45, 8'h00, 8'h00, 8'h1c, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h11,
           8'hab, 8'hcd, 8'hc0, 8'ha8, 8'h00, 8'h01, 8'hc0, 8'ha8, 8'h00, 8'hc7};

    repeat (3) @(negedge clk);
    check("rst_ih1", ih1, 0);
    check("rst_ih6", ih6, 0);
    check("rst_valid", hdr_valid, 0);
    check("rst_err", hdr_err, 0);
    check("rst_ready", in_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: 20-byte header, eop on byte 19, known words.
    expect_pkt(t1);
    for (int i = 0; i < 19; i++) send_byte(t1[i], i == 0, 1'b0);
    check("t1_pre_valid", hdr_valid, 0);
    send_byte(t1[19], 1'b0, 1'b1);
    check("t1_latency", hdr_valid, 1);
    check("t1_ih1", ih1, 32'h4500001c);
    check("t1_ih2", ih2, 32'h00010000);
    check("t1_ih3", ih3, 32'h40110000);
    check("t1_ih4", ih4, 32'hc0a80001);
    check("t1_ih5", ih5, 32'hc0a800c7);
    check("t1_ih6", ih6, 32'h00000000);
    check_counts("t1");

    // 2: IHL=6, 24 header bytes plus 8 payload bytes.
    pkt = {};
    pkt.push_back(8'h46);
    for (int i = 1; i < 32; i++) pkt.push_back(8'($urandom));
    send_pkt(pkt, 1'b1, 1'b0);
    check_counts("t2");

    // 3: consumer holds off for 5 cycles.
    ack_force = 5;
    pkt = {};
    pkt.push_back(8'h45);
    for (int i = 1; i < 20; i++) pkt.push_back(8'($urandom));
    send_pkt(pkt, 1'b1, 1'b0);
    repeat (10) @(negedge clk);
    ack_force = -1;
    check_counts("t3");

    // 4: version 6 is rejected and drained.
    pkt = {};
    pkt.push_back(8'h65);
    for (int i = 1; i < 12; i++) pkt.push_back(8'($urandom));
    send_pkt(pkt, 1'b1, 1'b0);
    check_counts("t4");

    // 5: eop on byte 11 of an IHL=5 header, then a good packet.
    pkt = {};
    for (int i = 0; i < 12; i++) pkt.push_back(t1[i]);
    send_pkt(pkt, 1'b1, 1'b0);
    send_pkt(t1, 1'b1, 1'b0);
    check_counts("t5");

    // 6: reset at byte 8; the stale tail is dropped, the next packet is collected.
    for (int i = 0; i < 8; i++) send_byte(t1[i], i == 0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("t6_rst_ih1", ih1, 0);
    check("t6_rst_ih2", ih2, 0);
    check("t6_rst_valid", hdr_valid, 0);
    check("t6_rst_ready", in_ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 8; i < 20; i++) send_byte(t1[i], 1'b0, i == 19);
    pkt = {};
    pkt.push_back(8'h45);
    for (int i = 1; i < 26; i++) pkt.push_back(8'($urandom));
    send_pkt(pkt, 1'b1, 1'b1);
    check_counts("t6");

    // Random packets: good, short, bad-first-byte, with or without eop.
    force_good = 1'b0;
    for (int p = 0; p < 80; p++) begin
      int         kind;
      int         hlen;
      int         len;
      bit         weop;
      logic [7:0] b0;
      kind = force_good ? 0 : $urandom_range(0, 9);
      if (kind <= 6) begin
        b0 = $urandom_range(0, 1) ? 8'h45 : 8'h46;
      end else begin
        b0 = 8'($urandom);
        while (b0[7:4] == 4'd4 && (b0[3:0] == 4'd5 || b0[3:0] == 4'd6)) b0 = 8'($urandom);
      end
      hlen = (b0 == 8'h46) ? 24 : 20;
      if (kind <= 5) len = hlen + $urandom_range(0, 10);
      else if (kind == 6) len = $urandom_range(1, hlen - 1);
      else len = $urandom_range(1, 12);
      weop = (p == 79) || ($urandom_range(0, 4) != 0);
      pkt = {};
      pkt.push_back(b0);
      for (int i = 1; i < len; i++) pkt.push_back(8'($urandom));
      send_pkt(pkt, weop, 1'b1);
      // A truncated short header errs on the next sop; keep that sop good so
      // the two error causes never share one pulse.
      force_good = (kind == 6) && !weop;
      if (weop && $urandom_range(0, 3) == 0)
        for (int g = 0; g < $urandom_range(1, 3); g++)
          send_byte(8'($urandom), 1'b0, 1'($urandom_range(0, 1)));
    end
    repeat (20) @(negedge clk);
    check("final_err", err_seen, err_exp);
    check("final_hdr", hdr_seen, hdr_exp);
    check("final_pending", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
